// File: rtl/mdu_ctrl_if.sv
// HI/LO unit handshake bundle: E-stage request, D-stage hazard query,
// and the architectural HI/LO view returned to the pipeline.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_use_D;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, hilo_use_D,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hilo_use_D,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV controller owning HI/LO: latches operands, counts
// a fixed latency, commits the result, and raises stall for HI/LO hazards.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b, q_u, r_u;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s;

    // Signed division via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
        q_u    = a_q / div_b;
        r_u    = a_q % div_b;
        abs_a  = a_q[31] ? -a_q : a_q;
        abs_b  = b_q[31] ? -b_q : div_b;
        q_mag  = abs_a / abs_b;
        r_mag  = abs_a % abs_b;
        q_s    = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
        r_s    = a_q[31] ? -r_mag : r_mag;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d = BUSY;
                            cnt_d   = (bus.op[1]) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            op_d    = bus.op;
                            a_d     = bus.src_a;
                            b_d     = bus.src_b;
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_d = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV:   if (b_q != 32'd0) {hi_d, lo_d} = {r_s, q_s};
                        OP_DIVU:  if (b_q != 32'd0) {hi_d, lo_d} = {r_u, q_u};
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state == BUSY);
        bus.stall = bus.hilo_use_D & (bus.busy | (bus.start & (bus.op <= 3'd3)));
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO and busy length,
// a monitor pops and compares at every busy falling edge.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   mon_run  = 0;
    logic mon_prev = 1'b0;
    logic mon_skip = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_op(input string name, input int cycles, input logic [31:0] h, input logic [31:0] l);
        sb.push_back('{name, cycles, h, l});
    endtask

    // Drives one start pulse now (caller sits just after an edge); returns just after the accepting edge.
    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'd7;
        bus.src_a = 32'h5A5A_5A5A;
        bus.src_b = 32'hA5A5_A5A5;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL wait_done: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    // Monitor: measures each busy run and checks it against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_run  = 0;
                mon_skip = 1'b1;
            end else if (bus.busy) begin
                mon_run++;
            end else begin
                if (mon_prev && !mon_skip) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got busy fall, expected none");
                    end else begin
                        mon_e = sb.pop_front();
                        check({mon_e.name, "_cycles"}, 64'(mon_run), 64'(mon_e.cycles));
                        check({mon_e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, mon_e.hi});
                        check({mon_e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, mon_e.lo});
                    end
                end
                mon_skip = 1'b0;
                mon_run  = 0;
            end
            mon_prev = bus.busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.op         = 3'd7;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.hilo_use_D = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_hi",    64'(bus.hi),    64'd0);
        check("rst_lo",    64'(bus.lo),    64'd0);
        @(posedge clk); #1;

        // MULT -1 x 2 with a dependent D-stage instruction held, MTHI attempted mid-busy
        bus.hilo_use_D = 1'b1;
        expect_op("mult_neg", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.src_a = 32'hFFFF_FFFF;
        bus.src_b = 32'h0000_0002;
        @(negedge clk);
        check("stall_start", 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'd7;
        bus.src_a = 32'h5A5A_5A5A;
        bus.src_b = 32'hA5A5_A5A5;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd4;
                bus.src_a = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            check("stall_busy", 64'(bus.stall), 64'd1);
            if (i == 3) check("hi_mid_busy", 64'(bus.hi), 64'd0);
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.op    = 3'd7;
        end
        @(negedge clk);
        check("stall_after", 64'(bus.stall), 64'd0);
        check("busy_after",  64'(bus.busy),  64'd0);
        bus.hilo_use_D = 1'b0;
        @(posedge clk); #1;

        // Back-to-back operations: each start lands in the cycle right after completion
        expect_op("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);
        drive(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(20);
        expect_op("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drive(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(20);

        drive(3'd4, 32'h1234_5678, 32'h0);
        check("mthi_hi",   64'(bus.hi),   64'h1234_5678);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        drive(3'd5, 32'h1234_5678, 32'h0);
        check("mtlo_lo",   64'(bus.lo),   64'h1234_5678);

        expect_op("divu_zero", 10, 32'h1234_5678, 32'h1234_5678);
        drive(3'd3, 32'h0000_0007, 32'h0000_0000);
        wait_done(20);
        expect_op("div_ovf", 10, 32'h0000_0000, 32'h8000_0000);
        drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(20);
        expect_op("divu_big", 10, 32'h0000_0001, 32'h7FFF_FFFC);
        drive(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(20);
        expect_op("div_negb", 10, 32'h0000_0001, 32'hFFFF_FFFD);
        drive(3'd2, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_done(20);

        drive(3'd5, 32'hCAFE_BABE, 32'h0);
        check("mtlo_cafe_lo",   64'(bus.lo),   64'hCAFE_BABE);
        check("mtlo_cafe_busy", 64'(bus.busy), 64'd0);
        check("mtlo_cafe_hi",   64'(bus.hi),   64'h0000_0001);
        drive(3'd6, 32'h0, 32'h0);
        drive(3'd7, 32'h0, 32'h0);
        check("nop_hi",   64'(bus.hi),   64'h0000_0001);
        check("nop_lo",   64'(bus.lo),   64'hCAFE_BABE);
        check("nop_busy", 64'(bus.busy), 64'd0);

        // Reset in the 3rd busy cycle of MULT 3x4, colliding with an MTHI request
        drive(3'd0, 32'd3, 32'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.src_a = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd7;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi",   64'(bus.hi),   64'd0);
        check("abort_lo",   64'(bus.lo),   64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("abort_hold_hilo", {bus.hi, bus.lo}, 64'd0);
            check("abort_hold_busy", 64'(bus.busy), 64'd0);
        end

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
